mc_control: RTL and testbench

- Multi-cycle controller for the next-generation CPU. It replaces the single-cycle combinational decode with a state machine that sequences fetch, decode, execute, memory and write-back over several cycles.
- Handshakes with a shared instruction/data memory through mem_ready, which allows variable memory latency.
- Parametrised memory-wait watchdog, a sticky trap state, and an instruction-retire counter.
- Sits between the instruction register (opcode/funct) and the datapath muxes, regfile, ALU and data memory.

---
 rtl/mc_pkg.sv | 81 ++++++++
 rtl/mc_wait_timer.sv | 30 +++
 rtl/mc_control.sv | 176 +++++++++++++++++
 tb/tb_mc_control.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/mc_pkg.sv
// Shared encodings for the multi-cycle controller: instruction fields, ALU
// commands, FSM states and datapath mux selects.
package mc_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_XORI  = 6'h0E;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_JR  = 6'h08;
  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_SLT = 6'h2A;

  localparam logic [2:0] ALU_ADD  = 3'd0;
  localparam logic [2:0] ALU_SUB  = 3'd1;
  localparam logic [2:0] ALU_XOR  = 3'd2;
  localparam logic [2:0] ALU_SLT  = 3'd3;
  localparam logic [2:0] ALU_AND  = 3'd4;
  localparam logic [2:0] ALU_NAND = 3'd5;
  localparam logic [2:0] ALU_NOR  = 3'd6;
  localparam logic [2:0] ALU_OR   = 3'd7;

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_EXEC_R, S_WB_R, S_EXEC_I, S_WB_I, S_MEM_ADDR,
    S_MEM_RD, S_WB_MEM, S_MEM_WR, S_BRANCH, S_JUMP, S_JR, S_TRAP
  } state_t;

  localparam logic [1:0] PC_ALU    = 2'd0;
  localparam logic [1:0] PC_ALUOUT = 2'd1;
  localparam logic [1:0] PC_JUMP   = 2'd2;
  localparam logic [1:0] PC_REGA   = 2'd3;

  localparam logic [1:0] RD_RT = 2'd0;
  localparam logic [1:0] RD_RD = 2'd1;
  localparam logic [1:0] RD_RA = 2'd2;

  localparam logic [1:0] WD_ALUOUT = 2'd0;
  localparam logic [1:0] WD_MDR    = 2'd1;
  localparam logic [1:0] WD_PC     = 2'd2;

  localparam logic [1:0] SRCB_REGB   = 2'd0;
  localparam logic [1:0] SRCB_FOUR   = 2'd1;
  localparam logic [1:0] SRCB_IMM    = 2'd2;
  localparam logic [1:0] SRCB_IMM_SH = 2'd3;

  localparam logic [1:0] TRAP_NONE    = 2'b00;
  localparam logic [1:0] TRAP_ILLEGAL = 2'b01;
  localparam logic [1:0] TRAP_TIMEOUT = 2'b10;

  function automatic state_t dispatch(input logic [5:0] op, input logic [5:0] fn);
    case (op)
      OP_RTYPE: begin
        case (fn)
          FN_ADD, FN_SUB, FN_SLT: return S_EXEC_R;
          FN_JR:                  return S_JR;
          default:                return S_TRAP;
        endcase
      end
      OP_LW, OP_SW:     return S_MEM_ADDR;
      OP_ADDI, OP_XORI: return S_EXEC_I;
      OP_BEQ, OP_BNE:   return S_BRANCH;
      OP_J, OP_JAL:     return S_JUMP;
      default:          return S_TRAP;
    endcase
  endfunction

  function automatic logic [2:0] alu_for_funct(input logic [5:0] fn);
    case (fn)
      FN_SUB:  return ALU_SUB;
      FN_SLT:  return ALU_SLT;
      default: return ALU_ADD;
    endcase
  endfunction

endpackage

// File: rtl/mc_wait_timer.sv
// Memory-wait watchdog: counts consecutive not-ready cycles in a memory state
// and flags the cycle on which the MAX_WAIT-th such cycle occurs.
module mc_wait_timer #(
  parameter int unsigned MAX_WAIT = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic waiting,
  input  logic ready,
  output logic timeout
);

  localparam int unsigned W = (MAX_WAIT > 1) ? $clog2(MAX_WAIT) : 1;

  logic [W-1:0] count;

  // Leaving a wait state always coincides with ready=1, so clearing on ready
  // also covers the clear-on-exit behaviour.
  always_ff @(posedge clk) begin
    if (reset || !waiting || ready) begin
      count <= '0;
    end else if (count != '1) begin
      count <= count + 1'b1;
    end
  end

  assign timeout = (MAX_WAIT != 0) && waiting && !ready &&
                   (32'(count) + 32'd1 >= MAX_WAIT);

endmodule

// File: rtl/mc_control.sv
// Multi-cycle CPU controller: sequences fetch/decode/execute/memory/write-back,
// with a memory-wait watchdog, sticky trap state and retired-instruction count.
module mc_control
  import mc_pkg::*;
#(
  parameter int unsigned MAX_WAIT = 16,
  parameter int unsigned CNT_W    = 32,
  parameter int unsigned CMD_W    = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [5:0]       opcode,
  input  logic [5:0]       funct,
  input  logic             zero,
  input  logic             mem_ready,
  output logic             pc_write,
  output logic [1:0]       pc_src,
  output logic             ir_write,
  output logic             mem_read,
  output logic             mem_write,
  output logic             i_or_d,
  output logic             reg_write,
  output logic [1:0]       reg_dst,
  output logic [1:0]       mem_to_reg,
  output logic             alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [CMD_W-1:0] alu_command,
  output logic             instr_done,
  output logic [CNT_W-1:0] retired,
  output logic             halted,
  output logic [1:0]       trap_cause
);

  state_t           state;
  state_t           next_dispatch;
  logic [1:0]       cause;
  logic [CNT_W-1:0] count;
  logic [2:0]       alu_cmd;
  logic             waiting;
  logic             timeout;

  assign waiting       = (state == S_FETCH) || (state == S_MEM_RD) || (state == S_MEM_WR);
  assign next_dispatch = dispatch(opcode, funct);

  mc_wait_timer #(.MAX_WAIT(MAX_WAIT)) u_wait_timer (
    .clk     (clk),
    .reset   (reset),
    .waiting (waiting),
    .ready   (mem_ready),
    .timeout (timeout)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_FETCH;
      cause <= TRAP_NONE;
      count <= '0;
    end else begin
      if (instr_done) count <= count + 1'b1;
      case (state)
        S_FETCH, S_MEM_RD, S_MEM_WR: begin
          if (mem_ready) begin
            state <= (state == S_FETCH)  ? S_DECODE :
                     (state == S_MEM_RD) ? S_WB_MEM : S_FETCH;
          end else if (timeout) begin
            state <= S_TRAP;
            cause <= TRAP_TIMEOUT;
          end
        end
        S_DECODE: begin
          state <= next_dispatch;
          if (next_dispatch == S_TRAP) cause <= TRAP_ILLEGAL;
        end
        S_EXEC_R:   state <= S_WB_R;
        S_EXEC_I:   state <= S_WB_I;
        S_MEM_ADDR: state <= (opcode == OP_SW) ? S_MEM_WR : S_MEM_RD;
        S_TRAP:     state <= S_TRAP;
        default:    state <= S_FETCH;
      endcase
    end
  end

  // Outputs decode the current state; reset forces every strobe low at once so
  // an instruction aborted mid-flight performs no further writes.
  always_comb begin
    pc_write   = 1'b0;
    pc_src     = PC_ALU;
    ir_write   = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    i_or_d     = 1'b0;
    reg_write  = 1'b0;
    reg_dst    = RD_RT;
    mem_to_reg = WD_ALUOUT;
    alu_src_a  = 1'b0;
    alu_src_b  = SRCB_REGB;
    alu_cmd    = ALU_ADD;
    instr_done = 1'b0;
    if (!reset) begin
      case (state)
        S_FETCH: begin
          mem_read  = 1'b1;
          alu_src_b = SRCB_FOUR;
          ir_write  = mem_ready;
          pc_write  = mem_ready;
        end
        S_DECODE: alu_src_b = SRCB_IMM_SH;
        S_EXEC_R: begin
          alu_src_a = 1'b1;
          alu_cmd   = alu_for_funct(funct);
        end
        S_WB_R: begin
          reg_write  = 1'b1;
          reg_dst    = RD_RD;
          instr_done = 1'b1;
        end
        S_EXEC_I: begin
          alu_src_a = 1'b1;
          alu_src_b = SRCB_IMM;
          alu_cmd   = (opcode == OP_XORI) ? ALU_XOR : ALU_ADD;
        end
        S_WB_I: begin
          reg_write  = 1'b1;
          instr_done = 1'b1;
        end
        S_MEM_ADDR: begin
          alu_src_a = 1'b1;
          alu_src_b = SRCB_IMM;
        end
        S_MEM_RD: begin
          mem_read = 1'b1;
          i_or_d   = 1'b1;
        end
        S_WB_MEM: begin
          reg_write  = 1'b1;
          mem_to_reg = WD_MDR;
          instr_done = 1'b1;
        end
        S_MEM_WR: begin
          mem_write  = 1'b1;
          i_or_d     = 1'b1;
          instr_done = mem_ready;
        end
        S_BRANCH: begin
          alu_src_a  = 1'b1;
          alu_cmd    = ALU_SUB;
          pc_src     = PC_ALUOUT;
          pc_write   = (opcode == OP_BEQ) ? zero : !zero;
          instr_done = 1'b1;
        end
        S_JUMP: begin
          pc_write   = 1'b1;
          pc_src     = PC_JUMP;
          instr_done = 1'b1;
          if (opcode == OP_JAL) begin
            reg_write  = 1'b1;
            reg_dst    = RD_RA;
            mem_to_reg = WD_PC;
          end
        end
        S_JR: begin
          pc_write   = 1'b1;
          pc_src     = PC_REGA;
          instr_done = 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign alu_command = CMD_W'(alu_cmd);
  assign retired     = reset ? '0 : count;
  assign halted      = !reset && (state == S_TRAP);
  assign trap_cause  = reset ? TRAP_NONE : cause;

endmodule

// File: tb/tb_mc_control.sv
// Randomized self-checking bench for mc_control: each instruction is scored
// against a class-level latency/strobe model derived from the ISA rules.
module tb_mc_control;

  localparam int unsigned MW = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [5:0]  opcode = '0;
  logic [5:0]  funct = '0;
  logic        zero = 1'b0;
  logic        mem_ready = 1'b0;
  logic        pc_write, ir_write, mem_read, mem_write, i_or_d, reg_write;
  logic        alu_src_a, instr_done, halted;
  logic [1:0]  pc_src, reg_dst, mem_to_reg, alu_src_b, trap_cause;
  logic [2:0]  alu_command;
  logic [31:0] retired;
  logic        strobes;

  always #5 clk = ~clk;

  mc_control #(.MAX_WAIT(MW), .CNT_W(32), .CMD_W(3)) dut (
    .clk(clk), .reset(reset), .opcode(opcode), .funct(funct), .zero(zero),
    .mem_ready(mem_ready), .pc_write(pc_write), .pc_src(pc_src),
    .ir_write(ir_write), .mem_read(mem_read), .mem_write(mem_write),
    .i_or_d(i_or_d), .reg_write(reg_write), .reg_dst(reg_dst),
    .mem_to_reg(mem_to_reg), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
    .alu_command(alu_command), .instr_done(instr_done), .retired(retired),
    .halted(halted), .trap_cause(trap_cause)
  );

  assign strobes = pc_write | ir_write | mem_read | mem_write | reg_write | instr_done;

  typedef enum int {C_R, C_JR, C_LW, C_SW, C_IALU, C_BR, C_J, C_JAL, C_ILL} cls_t;

  int          vectors = 0;
  int          errors = 0;
  int unsigned model_retired = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic cls_t classify(input logic [5:0] op, input logic [5:0] fn);
    case (op)
      6'h00: begin
        if (fn == 6'h20 || fn == 6'h22 || fn == 6'h2A) return C_R;
        if (fn == 6'h08) return C_JR;
        return C_ILL;
      end
      6'h23: return C_LW;
      6'h2B: return C_SW;
      6'h08, 6'h0E: return C_IALU;
      6'h04, 6'h05: return C_BR;
      6'h02: return C_J;
      6'h03: return C_JAL;
      default: return C_ILL;
    endcase
  endfunction

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    #1;
    check("reset_out", {strobes, halted, trap_cause, retired}, 64'd0);
    model_retired = 0;
  endtask

  // One instruction starting in its fetch cycle; f/m are not-ready cycles in
  // fetch and in the data access; abort_at asserts reset on that cycle.
  task automatic run_instr(input logic [5:0] op, input logic [5:0] fn, input int f,
                           input int m, input logic z, input int abort_at);
    cls_t c;
    bit is_mem, fetch_to, mem_to, ill, taken, seen_done, seen_halt;
    int tm, base, exp_done, exp_halt, end_at, irw_at;
    int n_pcw, n_irw, n_rd, n_wr, n_rw, exp_pcw, exp_rw;
    logic [1:0] rw_dst, rw_wd, end_pcsrc, exp_dst, exp_wd;
    logic [2:0] ex_alu, exp_alu;

    c        = classify(op, fn);
    is_mem   = (c == C_LW) || (c == C_SW);
    tm       = f + 3;
    fetch_to = (f >= int'(MW));
    mem_to   = is_mem && !fetch_to && (m >= int'(MW));
    ill      = (c == C_ILL) && !fetch_to;
    exp_halt = fetch_to ? int'(MW) : mem_to ? tm + int'(MW) : f + 2;
    case (c)
      C_LW:          base = 5;
      C_R, C_IALU:   base = 4;
      C_SW:          base = 4;
      default:       base = 3;
    endcase
    exp_done  = base - 1 + f + (is_mem ? m : 0);
    taken     = (op == 6'h04) ? z : !z;
    seen_done = 0; seen_halt = 0; end_at = -1; irw_at = -1;
    n_pcw = 0; n_irw = 0; n_rd = 0; n_wr = 0; n_rw = 0;
    rw_dst = '0; rw_wd = '0; end_pcsrc = '0; ex_alu = '0;

    for (int t = 0; t < 60; t++) begin
      @(negedge clk);
      reset  = (t == abort_at);
      opcode = op; funct = fn; zero = z;
      if (t < f)                                   mem_ready = 1'b0;
      else if (t == f)                             mem_ready = 1'b1;
      else if (is_mem && t >= tm && t < tm + m)    mem_ready = 1'b0;
      else if (is_mem && t == tm + m)              mem_ready = 1'b1;
      else                                         mem_ready = 1'($urandom_range(0, 1));
      #1;
      if (t == abort_at) begin
        check("abort_strobes", {strobes, reg_write}, 64'd0);
        return;
      end
      if (t == 0) begin
        check("fetch_first", {mem_read, i_or_d, alu_src_a, alu_src_b}, {1'b1, 1'b0, 1'b0, 2'd1});
        check("retired", retired, model_retired);
      end
      if (halted) begin
        seen_halt = 1; end_at = t;
        break;
      end
      if (pc_write) n_pcw++;
      if (ir_write) begin n_irw++; irw_at = t; end
      if (mem_read) n_rd++;
      if (mem_write) n_wr++;
      if (reg_write) begin n_rw++; rw_dst = reg_dst; rw_wd = mem_to_reg; end
      if (t == f + 2) ex_alu = alu_command;
      if (instr_done) begin
        seen_done = 1; end_at = t; end_pcsrc = pc_src;
        break;
      end
    end

    if (fetch_to || mem_to || ill) begin
      check("halt_at", 64'(end_at), 64'(exp_halt));
      check("trap_no_done", 64'(seen_done), 64'd0);
      for (int k = 0; k < 3; k++) begin
        @(negedge clk);
        mem_ready = 1'($urandom_range(0, 1));
        #1;
        check("trap_hold", {halted, trap_cause, strobes},
              {1'b1, (ill ? 2'b01 : 2'b10), 1'b0});
      end
      check("trap_retired", retired, model_retired);
      do_reset();
    end else begin
      check("done_at", 64'(end_at), 64'(exp_done));
      check("ir_write", {32'(n_irw), 32'(irw_at)}, {32'd1, 32'(f)});
      exp_pcw = 1 + ((c == C_BR && taken) ? 1 : 0) + ((c == C_J || c == C_JAL || c == C_JR) ? 1 : 0);
      check("pc_write_n", 64'(n_pcw), 64'(exp_pcw));
      check("mem_rd_wr_n", {32'(n_rd), 32'(n_wr)},
            {32'(f + 1 + (c == C_LW ? m + 1 : 0)), 32'(c == C_SW ? m + 1 : 0)});
      exp_rw  = (c == C_R || c == C_IALU || c == C_LW || c == C_JAL) ? 1 : 0;
      exp_dst = (c == C_R) ? 2'd1 : (c == C_JAL) ? 2'd2 : 2'd0;
      exp_wd  = (c == C_LW) ? 2'd1 : (c == C_JAL) ? 2'd2 : 2'd0;
      check("reg_write_n", 64'(n_rw), 64'(exp_rw));
      if (exp_rw == 1) check("reg_write_sel", {rw_dst, rw_wd}, {exp_dst, exp_wd});
      if (c == C_BR)  check("pc_src_br", end_pcsrc, 2'd1);
      if (c == C_J || c == C_JAL) check("pc_src_j", end_pcsrc, 2'd2);
      if (c == C_JR)  check("pc_src_jr", end_pcsrc, 2'd3);
      if (c == C_R || c == C_IALU || is_mem || c == C_BR) begin
        exp_alu = (c == C_BR) ? 3'd1 :
                  (c == C_R && fn == 6'h22) ? 3'd1 :
                  (c == C_R && fn == 6'h2A) ? 3'd3 :
                  (c == C_IALU && op == 6'h0E) ? 3'd2 : 3'd0;
        check("alu_cmd", ex_alu, exp_alu);
      end
      model_retired++;
    end
  endtask

  initial begin
    logic [5:0] op, fn;
    int f, m;
    do_reset();
    run_instr(6'h00, 6'h20, 0, 0, 1'b0, -1);
    run_instr(6'h23, 6'h11, 0, 0, 1'b0, -1);
    run_instr(6'h2B, 6'h00, 0, 0, 1'b0, -1);
    run_instr(6'h04, 6'h00, 0, 0, 1'b1, -1);
    run_instr(6'h03, 6'h00, 0, 0, 1'b0, -1);
    run_instr(6'h05, 6'h00, 0, 0, 1'b1, -1);
    run_instr(6'h05, 6'h00, 0, 0, 1'b0, -1);
    run_instr(6'h23, 6'h00, 3, 2, 1'b0, -1);
    run_instr(6'h2B, 6'h00, 0, 3, 1'b0, -1);
    run_instr(6'h2B, 6'h00, 0, 4, 1'b0, -1);
    run_instr(6'h3F, 6'h00, 0, 0, 1'b0, -1);
    run_instr(6'h00, 6'h3F, 1, 0, 1'b0, -1);
    run_instr(6'h00, 6'h22, 1, 0, 1'b0, 3);
    do_reset();
    run_instr(6'h00, 6'h2A, 2, 0, 1'b0, -1);

    for (int n = 0; n < 150; n++) begin
      fn = 6'($urandom);
      case ($urandom_range(0, 14))
        0:  begin op = 6'h00; fn = 6'h20; end
        1:  begin op = 6'h00; fn = 6'h22; end
        2:  begin op = 6'h00; fn = 6'h2A; end
        3:  begin op = 6'h00; fn = 6'h08; end
        4:  op = 6'h23;
        5:  op = 6'h2B;
        6:  op = 6'h08;
        7:  op = 6'h0E;
        8:  op = 6'h04;
        9:  op = 6'h05;
        10: op = 6'h02;
        11: op = 6'h03;
        12: op = 6'h23;
        13: op = 6'h2B;
        default: op = ($urandom_range(0, 1) == 0) ? 6'h3F : 6'h11;
      endcase
      f = ($urandom_range(0, 11) == 0) ? int'(MW) : int'($urandom_range(0, 2));
      m = ($urandom_range(0, 7) == 0) ? int'(MW) : int'($urandom_range(0, 3));
      run_instr(op, fn, f, m, 1'($urandom_range(0, 1)), -1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
